// File: rtl/mips_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_pkg -- shared constants and types for the MIPS front end            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam logic [31:0] RESET_PC        = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam logic [31:0] PC8_OFFSET      = 32'd8;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu.sv
// +--------------------------------------------------------------------------+
// | ifu -- instruction fetch unit with a one-entry buffer and delay slot     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc8_f,
  output logic        fetch_valid
);

  import mips_pkg::*;

  ifu_state_t  state;
  ifu_state_t  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] instr_buf;
  logic [31:0] instr_buf_next;
  logic [31:0] pc8_buf;
  logic [31:0] pc8_buf_next;
  logic [31:0] redir_pc;
  logic [31:0] redir_pc_next;
  logic        redir_pending;
  logic        redir_pending_next;
  logic        redirect_ok;
  logic [31:0] target_aligned;

  assign redirect_ok    = npc_sel && !stall;
  assign target_aligned = npc_target & ADDR_ALIGN_MASK;

  always_comb begin
    state_next         = state;
    pc_next            = pc;
    instr_buf_next     = instr_buf;
    pc8_buf_next       = pc8_buf;
    redir_pc_next      = redir_pc;
    redir_pending_next = redir_pending;

    case (state)
      FETCH: begin
        // A redirect seen while fetching belongs after the in-flight delay slot
        if (redirect_ok) begin
          redir_pc_next      = target_aligned;
          redir_pending_next = 1'b1;
        end
        if (imem_ready) begin
          instr_buf_next = imem_rdata;
          pc8_buf_next   = pc + PC8_OFFSET;
          state_next     = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_next         = FETCH;
          redir_pending_next = 1'b0;
          if (npc_sel) begin
            pc_next = target_aligned;
          end else if (redir_pending) begin
            pc_next = redir_pc;
          end else begin
            pc_next = pc + PC_STEP;
          end
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= FETCH;
      pc            <= RESET_PC & ADDR_ALIGN_MASK;
      instr_buf     <= NOP_INSTR;
      pc8_buf       <= RESET_PC + PC8_OFFSET;
      redir_pending <= 1'b0;
      redir_pc      <= 32'h0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      instr_buf     <= instr_buf_next;
      pc8_buf       <= pc8_buf_next;
      redir_pending <= redir_pending_next;
      redir_pc      <= redir_pc_next;
    end
  end

  // Outputs depend on registered state only; no memory-to-decode path
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc & ADDR_ALIGN_MASK;
  assign fetch_valid = (state == HOLD);
  assign instr_f     = fetch_valid ? instr_buf : NOP_INSTR;
  assign pc8_f       = fetch_valid ? pc8_buf : (pc + PC8_OFFSET);

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
// +--------------------------------------------------------------------------+
// | tb_ifu -- scoreboard bench for the instruction fetch unit                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ifu;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        npc_sel;
  logic [31:0] npc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc8_f;
  logic        fetch_valid;

  int          checks = 0;
  int          passes = 0;
  int          lat    = 1;
  logic [31:0] exp_q[$];

  ifu #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .npc_target (npc_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr_f    (instr_f),
    .pc8_f      (pc8_f),
    .fetch_valid(fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  // Memory model: ready once a stable request has been seen for lat cycles
  initial begin
    int          cnt;
    logic [31:0] last_addr;
    cnt        = 0;
    last_addr  = 32'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (!reset || !imem_req) begin
        cnt        = 0;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end else begin
        if (imem_addr != last_addr) cnt = 0;
        cnt++;
        last_addr  = imem_addr;
        imem_ready = (cnt >= lat);
        imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: every handoff to decode must match the next expected fetch
  always @(negedge clk) begin
    if (reset && fetch_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_handoff: got pc8 %h, expected no handoff", pc8_f);
      end else begin
        logic [31:0] a;
        a = exp_q.pop_front();
        chk("sb_instr", instr_f, mem_word(a));
        chk("sb_pc8", pc8_f, a + 32'd8);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fv(input string name);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fetch_valid) return;
    end
    timeout(name);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (exp_q.size() == 0) return;
    end
    timeout(name);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (imem_ready) return;
    end
    timeout(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    stall      = 1'b1;
    npc_sel    = 1'b0;
    npc_target = 32'h0;
    repeat (3) @(posedge clk);
    tick();
    chk("rst_instr", instr_f, 32'h0);
    chk("rst_pc8", pc8_f, 32'h3008);
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h3000);

    // Sequential stream with single-cycle memory
    exp_q.push_back(32'h3000);
    exp_q.push_back(32'h3004);
    exp_q.push_back(32'h3008);
    drive_edge();
    reset = 1'b1;
    stall = 1'b0;
    wait_fv("first_valid");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alternate", {31'b0, fetch_valid}, (i % 2 == 0) ? 32'h0 : 32'h1);
    end
    drive_edge();
    stall = 1'b1;

    // Stalled HOLD keeps everything frozen
    wait_fv("stall_hold");
    for (int i = 0; i < 5; i++) begin
      chk("hold_instr", instr_f, mem_word(32'h300C));
      chk("hold_pc8", pc8_f, 32'h3014);
      chk("hold_valid", {31'b0, fetch_valid}, 32'h1);
      chk("hold_req", {31'b0, imem_req}, 32'h0);
      tick();
    end
    exp_q.push_back(32'h300C);
    drive_edge();
    stall = 1'b0;
    lat   = 4;
    wait_empty("stall_release");

    // Slow memory: address held steady, no valid until data arrives
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("slow_addr", imem_addr, 32'h3010);
      chk("slow_req", {31'b0, imem_req}, 32'h1);
      chk("slow_valid", {31'b0, fetch_valid}, 32'h0);
    end
    exp_q.push_back(32'h3010);
    wait_empty("slow_fetch");

    // Two qualified redirects during a fetch: the later target wins after the delay slot
    drive_edge();
    npc_sel    = 1'b1;
    npc_target = 32'h3300;
    drive_edge();
    npc_target = 32'h3100;
    drive_edge();
    npc_sel = 1'b0;
    exp_q.push_back(32'h3014);
    exp_q.push_back(32'h3100);
    wait_empty("redirect");

    // Redirect under stall must be ignored
    drive_edge();
    stall      = 1'b1;
    npc_sel    = 1'b1;
    npc_target = 32'h3200;
    drive_edge();
    npc_sel = 1'b0;
    wait_fv("stalled_redirect");
    exp_q.push_back(32'h3104);
    drive_edge();
    stall = 1'b0;
    wait_empty("stalled_redirect_handoff");
    drive_edge();
    stall = 1'b1;
    tick();
    chk("no_redirect_addr", imem_addr, 32'h3108);

    // Redirect on the handoff edge, then wrap past the top of memory
    wait_fv("handoff_redirect");
    exp_q.push_back(32'h3108);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    drive_edge();
    stall      = 1'b0;
    npc_sel    = 1'b1;
    npc_target = 32'hFFFF_FFFC;
    drive_edge();
    npc_sel = 1'b0;
    tick();
    chk("handoff_target_addr", imem_addr, 32'hFFFF_FFFC);
    wait_empty("wrap");
    drive_edge();
    stall = 1'b1;

    // Reset while memory answers: response discarded, restart at RESET_PC
    wait_ready("reset_mid_fetch");
    reset = 1'b0;
    exp_q.delete();
    drive_edge();
    reset = 1'b1;
    tick();
    chk("rst2_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst2_req", {31'b0, imem_req}, 32'h1);
    chk("rst2_addr", imem_addr, 32'h3000);
    chk("rst2_instr", instr_f, 32'h0);
    chk("rst2_pc8", pc8_f, 32'h3008);
    lat = 1;
    exp_q.push_back(32'h3000);
    drive_edge();
    stall = 1'b0;
    wait_empty("post_reset_fetch");
    drive_edge();
    stall = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
